// File: rtl/prog_ctr_seq.sv
// Fetch-stage program counter: sequences resident programs on Start and supports
// conditional branches, a call/return stack, stall, halt/done and sticky stack errors.
module prog_ctr_seq #(
  parameter int                         PC_W        = 10,
  parameter int                         NUM_PROGS   = 3,
  parameter logic [NUM_PROGS*PC_W-1:0]  PROG_BASE   = {10'd256, 10'd128, 10'd0},
  parameter int                         STACK_DEPTH = 4
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Start,
  input  logic                               Stall,
  input  logic                               BranchRel,
  input  logic                               BranchAbs,
  input  logic                               ALU_flag,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic                               Halt,
  input  logic [PC_W-1:0]                    Target,
  output logic [PC_W-1:0]                    ProgCtr,
  output logic [$clog2(NUM_PROGS+1)-1:0]     ProgIdx,
  output logic                               Running,
  output logic                               Done,
  output logic                               StackErr,
  output logic [1:0]                         dbg_state
);

  localparam int IDX_W = $clog2(NUM_PROGS + 1);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int TAB_N = 1 << IDX_W;
  localparam int STK_N = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [SP_W-1:0]   sp, sp_n;
  logic              err, err_n;
  logic              running, done;
  logic              push;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [PC_W-1:0]   stack [STK_N];
  logic [PC_W-1:0]   base_tab [TAB_N];

  // Entry-address table padded to a power of two so ProgIdx can index it directly.
  for (genvar g = 0; g < TAB_N; g++) begin : g_base
    if (g < NUM_PROGS) begin : g_used
      assign base_tab[g] = PROG_BASE[g*PC_W +: PC_W];
    end else begin : g_pad
      assign base_tab[g] = '0;
    end
  end

  assign wr_addr = AW'(sp);
  assign rd_addr = AW'(sp - SP_W'(1));

  always_comb begin
    state_n = state;
    pc_n    = pc;
    idx_n   = idx;
    sp_n    = sp;
    err_n   = err;
    push    = 1'b0;
    if (Start) begin
      pc_n    = base_tab[idx];
      idx_n   = (idx == IDX_W'(NUM_PROGS - 1)) ? '0 : idx + IDX_W'(1);
      sp_n    = '0;
      err_n   = 1'b0;
      state_n = S_RUN;
    end else if (state == S_RUN && !Stall) begin
      if (Halt) begin
        state_n = S_HALT;
      end else if (Ret) begin
        if (sp != '0) begin
          sp_n = sp - SP_W'(1);
          pc_n = stack[rd_addr];
        end else begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end
      end else if (Call) begin
        if (sp != SP_W'(STACK_DEPTH)) begin
          push = 1'b1;
          sp_n = sp + SP_W'(1);
          pc_n = Target;
        end else begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end
      end else if (BranchAbs && ALU_flag) begin
        pc_n = Target;
      end else if (BranchRel && ALU_flag) begin
        // Same-width add wraps modulo 2^PC_W, which equals adding the sign-extended offset.
        pc_n = pc + Target;
      end else begin
        pc_n = pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      idx     <= '0;
      sp      <= '0;
      err     <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      idx     <= idx_n;
      sp      <= sp_n;
      err     <= err_n;
      running <= (state_n == S_RUN);
      done    <= (state_n == S_HALT);
    end
  end

  // Stack storage needs no reset: the pointer alone defines which entries are live.
  always_ff @(posedge Clk) begin
    if (!Reset && push) stack[wr_addr] <= pc + PC_W'(1);
  end

  assign ProgCtr   = pc;
  assign ProgIdx   = idx;
  assign Running   = running;
  assign Done      = done;
  assign StackErr  = err;
  assign dbg_state = state;

endmodule
